// File: rtl/wb_ext_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ext_rr_arbiter
//  Purpose  : Round-robin Wishbone B3 arbiter that shares one external slave
//             among NUM_MASTERS tile-level wb_ext master ports. A master owns
//             the slave for its whole bus cycle (cyc high, bursts included).
//             Grants are registered, and one IDLE cycle always separates two
//             grants.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             m_*_i               - packed per-master request bundles
//             m_ack/rty/err_o     - per-master responses (granted slot only)
//             m_dat_o             - slave read data broadcast to every slot
//             s_*_o / s_*_i       - single slave port
//             grant_o             - registered one-hot grant (0 when idle)
//             timeout_o           - one-cycle pulse on forced termination
//  Options  : `define WB_EXT_ARB_TIMEOUT_EN builds a response watchdog that
//             errors out a stalled transfer after TIMEOUT cycles. Without it
//             timeout_o is tied low and a grant is held indefinitely.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_ext_rr_arbiter #(
    parameter int NUM_MASTERS = 36,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS-1:0]               m_cab_i,
    input  logic [NUM_MASTERS*3-1:0]             m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]             m_bte_i,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_rty_o,
    output logic [NUM_MASTERS-1:0]               m_err_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_o,
    output logic [ADDR_WIDTH-1:0]                s_adr_o,
    output logic [DATA_WIDTH-1:0]                s_dat_o,
    output logic [DATA_WIDTH/8-1:0]              s_sel_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic                                 s_we_o,
    output logic                                 s_cab_o,
    output logic [2:0]                           s_cti_o,
    output logic [1:0]                           s_bte_o,
    input  logic                                 s_ack_i,
    input  logic                                 s_rty_i,
    input  logic                                 s_err_i,
    input  logic [DATA_WIDTH-1:0]                s_dat_i,
    output logic [NUM_MASTERS-1:0]               grant_o,
    output logic                                 timeout_o
);

    localparam int c_sel_w  = DATA_WIDTH / 8;
    localparam int c_ptr_w  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    // One extra bit so rr_ptr + k never overflows before the wrap compare.
    localparam int c_cand_w = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0]     c_last_idx = c_ptr_w'(NUM_MASTERS - 1);
    localparam logic [c_cand_w-1:0]    c_num_m    = c_cand_w'(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] c_one      = NUM_MASTERS'(1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    logic [0:0]             r_state,   w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant,   w_grant_nxt;
    logic [c_ptr_w-1:0]     r_gidx,    w_gidx_nxt;
    logic [c_ptr_w-1:0]     r_rr_ptr,  w_rr_ptr_nxt;

    logic [c_cand_w-1:0]    w_cand;
    logic [c_ptr_w-1:0]     w_sel_idx;
    logic                   w_sel_found;
    logic [c_ptr_w-1:0]     w_next_ptr;
    logic                   w_g_cyc;
    logic                   w_g_stb;
    logic                   w_timeout;

    // ------------------------------------------------------------------
    // Round-robin search: first requester at or after rr_ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_cand = {1'b0, r_rr_ptr} + c_cand_w'(k);
            if (w_cand >= c_num_m) begin
                w_cand = w_cand - c_num_m;
            end
            if (!w_sel_found && m_cyc_i[w_cand[c_ptr_w-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand[c_ptr_w-1:0];
            end
        end
    end

    // Explicit compare so non-power-of-two master counts wrap correctly.
    assign w_next_ptr = (r_gidx == c_last_idx) ? '0 : r_gidx + c_ptr_w'(1);

    // ------------------------------------------------------------------
    // Request mux. r_grant is all-zero outside GRANT, so every slave-side
    // output naturally reads zero when idle.
    // ------------------------------------------------------------------
    always_comb begin
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cab_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_g_cyc = m_cyc_i[i];
                w_g_stb = m_stb_i[i];
                s_adr_o = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                s_sel_o = m_sel_i[i*c_sel_w +: c_sel_w];
                s_we_o  = m_we_i[i];
                s_cab_o = m_cab_i[i];
                s_cti_o = m_cti_i[i*3 +: 3];
                s_bte_o = m_bte_i[i*2 +: 2];
            end
        end
    end

    // A forced termination drops cyc/stb in the same cycle the error fires.
    assign s_cyc_o = w_g_cyc & ~w_timeout;
    assign s_stb_o = w_g_stb & ~w_timeout;

    assign m_ack_o = r_grant & {NUM_MASTERS{s_ack_i}};
    assign m_rty_o = r_grant & {NUM_MASTERS{s_rty_i}};
    assign m_err_o = r_grant & {NUM_MASTERS{s_err_i | w_timeout}};
    // Read data is only meaningful to the slot that sees ack.
    assign m_dat_o = {NUM_MASTERS{s_dat_i}};

    assign grant_o   = r_grant;
    assign timeout_o = w_timeout;

    // ------------------------------------------------------------------
    // Response watchdog
    // ------------------------------------------------------------------
`ifdef WB_EXT_ARB_TIMEOUT_EN
    localparam int                  c_tmo_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               w_resp;

    assign w_resp = s_ack_i | s_err_i | s_rty_i;

    // The counter holds the number of stalled cycles already seen, so the
    // TIMEOUT-th stalled cycle is the one where it equals TIMEOUT-1.
    assign w_timeout = (r_state == c_st_grant) && w_g_stb && !w_resp &&
                       (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state != c_st_grant) begin
            r_tmo_cnt <= '0;
        end else if (w_resp) begin
            r_tmo_cnt <= '0;
        end else if (w_g_stb) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
        end
    end
`else
    // TIMEOUT only matters when the watchdog is compiled in.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT < 1);
    assign w_timeout        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_gidx_nxt   = r_gidx;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            c_st_idle: begin
                if (w_sel_found) begin
                    w_state_nxt = c_st_grant;
                    w_grant_nxt = c_one << w_sel_idx;
                    w_gidx_nxt  = w_sel_idx;
                end
            end
            c_st_grant: begin
                // Requests from other slots are not looked at here; they
                // compete in the IDLE cycle that follows the release.
                if (!w_g_cyc || w_timeout) begin
                    w_state_nxt  = c_st_idle;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = w_next_ptr;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_ext_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_ext_rr_arbiter
//  Purpose  : Self-checking bench for wb_ext_rr_arbiter: a vector table for
//             the basic grant/rotation behaviour, hand sequences for bursts,
//             reset mid-transfer and stall handling, then random traffic
//             checked against an ownership/pointer reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_ext_rr_arbiter;

    localparam int c_n  = 36;
    localparam int c_aw = 32;
    localparam int c_dw = 32;
    localparam int c_sw = c_dw / 8;
`ifdef WB_EXT_ARB_TIMEOUT_EN
    localparam int c_tmo = 4;
`else
    localparam int c_tmo = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Per-slot stimulus kept as arrays, packed onto the DUT buses below.
    logic [c_aw-1:0] adr [c_n];
    logic [c_dw-1:0] dat [c_n];
    logic [c_sw-1:0] sel [c_n];
    logic [2:0]      cti [c_n];
    logic [1:0]      bte [c_n];
    logic [c_n-1:0]  cyc, stb, we, cab;

    logic [c_n*c_aw-1:0] m_adr_i;
    logic [c_n*c_dw-1:0] m_dat_i;
    logic [c_n*c_sw-1:0] m_sel_i;
    logic [c_n*3-1:0]    m_cti_i;
    logic [c_n*2-1:0]    m_bte_i;

    always_comb begin
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '0;
        m_cti_i = '0;
        m_bte_i = '0;
        for (int i = 0; i < c_n; i++) begin
            m_adr_i[i*c_aw +: c_aw] = adr[i];
            m_dat_i[i*c_dw +: c_dw] = dat[i];
            m_sel_i[i*c_sw +: c_sw] = sel[i];
            m_cti_i[i*3 +: 3]       = cti[i];
            m_bte_i[i*2 +: 2]       = bte[i];
        end
    end

    logic [c_n-1:0]      m_ack_o, m_rty_o, m_err_o, grant_o;
    logic [c_n*c_dw-1:0] m_dat_o;
    logic [c_aw-1:0]     s_adr_o;
    logic [c_dw-1:0]     s_dat_o;
    logic [c_sw-1:0]     s_sel_o;
    logic                s_cyc_o, s_stb_o, s_we_o, s_cab_o, timeout_o;
    logic [2:0]          s_cti_o;
    logic [1:0]          s_bte_o;
    logic                s_ack, s_rty, s_err;
    logic [c_dw-1:0]     s_dat;

    wb_ext_rr_arbiter #(
        .NUM_MASTERS (c_n),
        .ADDR_WIDTH  (c_aw),
        .DATA_WIDTH  (c_dw),
        .TIMEOUT     (c_tmo)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_cyc_i   (cyc),
        .m_stb_i   (stb),
        .m_we_i    (we),
        .m_cab_i   (cab),
        .m_cti_i   (m_cti_i),
        .m_bte_i   (m_bte_i),
        .m_ack_o   (m_ack_o),
        .m_rty_o   (m_rty_o),
        .m_err_o   (m_err_o),
        .m_dat_o   (m_dat_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_cab_o   (s_cab_o),
        .s_cti_o   (s_cti_o),
        .s_bte_o   (s_bte_o),
        .s_ack_i   (s_ack),
        .s_rty_i   (s_rty),
        .s_err_i   (s_err),
        .s_dat_i   (s_dat),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the bus (-1 = nobody), where the next
    // search starts, and how many stalled cycles the owner has seen.
    // ------------------------------------------------------------------
    int   mdl_owner = -1;
    int   mdl_ptr   = 0;
    int   mdl_cnt   = 0;
    logic mdl_tmo   = 1'b0;

    task automatic model_compare();
        int o;
        logic resp;
        logic [63:0] e_grant, e_ack, e_rty, e_err;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        logic [2:0]  e_cti;
        logic [1:0]  e_bte;
        logic        e_cyc, e_stb, e_we, e_cab;
        o    = mdl_owner;
        resp = s_ack | s_err | s_rty;
        mdl_tmo = 1'b0;
`ifdef WB_EXT_ARB_TIMEOUT_EN
        if (o >= 0) mdl_tmo = stb[o] && !resp && (mdl_cnt == c_tmo - 1);
`endif
        e_grant = '0; e_ack = '0; e_rty = '0; e_err = '0;
        e_adr = '0; e_dat = '0; e_sel = '0; e_cti = '0; e_bte = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_cab = 1'b0;
        if (o >= 0) begin
            e_grant = 64'(1) << o;
            e_cyc   = cyc[o] & ~mdl_tmo;
            e_stb   = stb[o] & ~mdl_tmo;
            e_adr   = adr[o];
            e_dat   = dat[o];
            e_sel   = sel[o];
            e_we    = we[o];
            e_cab   = cab[o];
            e_cti   = cti[o];
            e_bte   = bte[o];
            e_ack   = s_ack ? e_grant : '0;
            e_rty   = s_rty ? e_grant : '0;
            e_err   = (s_err | mdl_tmo) ? e_grant : '0;
        end
        chk("grant_o",   64'(grant_o),   e_grant);
        chk("s_cyc_o",   64'(s_cyc_o),   64'(e_cyc));
        chk("s_stb_o",   64'(s_stb_o),   64'(e_stb));
        chk("s_adr_o",   64'(s_adr_o),   64'(e_adr));
        chk("s_dat_o",   64'(s_dat_o),   64'(e_dat));
        chk("s_sel_o",   64'(s_sel_o),   64'(e_sel));
        chk("s_we_o",    64'(s_we_o),    64'(e_we));
        chk("s_cab_o",   64'(s_cab_o),   64'(e_cab));
        chk("s_cti_o",   64'(s_cti_o),   64'(e_cti));
        chk("s_bte_o",   64'(s_bte_o),   64'(e_bte));
        chk("m_ack_o",   64'(m_ack_o),   e_ack);
        chk("m_rty_o",   64'(m_rty_o),   e_rty);
        chk("m_err_o",   64'(m_err_o),   e_err);
        chk("timeout_o", 64'(timeout_o), 64'(mdl_tmo));
        chk("m_dat_o",   {m_dat_o[0 +: 32], m_dat_o[(c_n-1)*c_dw +: 32]}, {s_dat, s_dat});
    endtask

    task automatic model_update();
        if (rst) begin
            mdl_owner = -1;
            mdl_ptr   = 0;
            mdl_cnt   = 0;
        end else if (mdl_owner < 0) begin
            for (int k = 0; k < c_n; k++) begin
                if (mdl_owner < 0 && cyc[(mdl_ptr + k) % c_n]) begin
                    mdl_owner = (mdl_ptr + k) % c_n;
                    mdl_cnt   = 0;
                end
            end
        end else if (!cyc[mdl_owner] || mdl_tmo) begin
            mdl_ptr   = (mdl_owner + 1) % c_n;
            mdl_owner = -1;
        end else if (s_ack | s_err | s_rty) begin
            mdl_cnt = 0;
        end else if (stb[mdl_owner]) begin
            mdl_cnt++;
        end
    endtask

    // Called after the negedge sample point: compare, advance one edge.
    task automatic finish_cycle();
        model_compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < c_n; i++) begin
            adr[i] = (i == 3) ? 32'h0000_1000 : (32'hA000_0000 | 32'(i));
            dat[i] = 32'h5A00_0000 | 32'(i);
            sel[i] = 4'hF;
            cti[i] = 3'b000;
            bte[i] = 2'b00;
        end
        cyc = '0; stb = '0; we = '0; cab = '0;
        s_ack = 1'b0; s_rty = 1'b0; s_err = 1'b0; s_dat = 32'hD00D_0000;
    endtask

    typedef struct {
        logic            rst;
        logic [c_n-1:0]  cyc;
        logic            ack;
        logic [c_n-1:0]  exp_grant;
        logic            exp_scyc;
        logic [31:0]     exp_sadr;
        logic [c_n-1:0]  exp_ack;
    } vec_t;

    function automatic vec_t mk(logic r, logic [c_n-1:0] c, logic a, logic [c_n-1:0] g,
                                logic sc, logic [31:0] sa, logic [c_n-1:0] ak);
        vec_t v;
        v.rst = r; v.cyc = c; v.ack = a; v.exp_grant = g;
        v.exp_scyc = sc; v.exp_sadr = sa; v.exp_ack = ak;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [19];
        logic [c_n-1:0] b0, b1, b2, b3, b5, b7, b9, b35;
        logic [2:0] exp_cti;
        b0 = c_n'(1); b1 = b0 << 1; b2 = b0 << 2; b3 = b0 << 3;
        b5 = b0 << 5; b7 = b0 << 7; b9 = b0 << 9; b35 = b0 << 35;

        // Single transfer from slot 3, then slots 0/5/35 rotating with wrap.
        vecs[0]  = mk(0, '0,           0, '0,  0, 32'h0,         '0);
        vecs[1]  = mk(0, b3,           0, '0,  0, 32'h0,         '0);
        vecs[2]  = mk(0, b3,           1, b3,  1, 32'h0000_1000, b3);
        vecs[3]  = mk(0, '0,           0, b3,  0, 32'h0000_1000, '0);
        vecs[4]  = mk(0, '0,           0, '0,  0, 32'h0,         '0);
        vecs[5]  = mk(1, '0,           0, '0,  0, 32'h0,         '0);
        vecs[6]  = mk(0, b0|b5|b35,    0, '0,  0, 32'h0,         '0);
        vecs[7]  = mk(0, b0|b5|b35,    1, b0,  1, 32'hA000_0000, b0);
        vecs[8]  = mk(0, b5|b35,       0, b0,  0, 32'hA000_0000, '0);
        vecs[9]  = mk(0, b0|b5|b35,    0, '0,  0, 32'h0,         '0);
        vecs[10] = mk(0, b0|b5|b35,    1, b5,  1, 32'hA000_0005, b5);
        vecs[11] = mk(0, b0|b35,       0, b5,  0, 32'hA000_0005, '0);
        vecs[12] = mk(0, b0|b5|b35,    0, '0,  0, 32'h0,         '0);
        vecs[13] = mk(0, b0|b5|b35,    1, b35, 1, 32'hA000_0023, b35);
        vecs[14] = mk(0, b0|b5,        0, b35, 0, 32'hA000_0023, '0);
        vecs[15] = mk(0, b0|b5|b35,    0, '0,  0, 32'h0,         '0);
        vecs[16] = mk(0, b0|b5|b35,    1, b0,  1, 32'hA000_0000, b0);
        vecs[17] = mk(0, '0,           0, b0,  0, 32'hA000_0000, '0);
        vecs[18] = mk(0, '0,           0, '0,  0, 32'h0,         '0);

        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        @(negedge clk);
        finish_cycle();
        rst = 1'b0;

        // ---------------- vector table ----------------
        for (int r = 0; r < 19; r++) begin
            rst   = vecs[r].rst;
            cyc   = vecs[r].cyc;
            stb   = vecs[r].cyc;
            s_ack = vecs[r].ack;
            @(negedge clk);
            chk($sformatf("vec%0d_grant", r), 64'(grant_o), 64'(vecs[r].exp_grant));
            chk($sformatf("vec%0d_scyc", r),  64'(s_cyc_o), 64'(vecs[r].exp_scyc));
            chk($sformatf("vec%0d_sadr", r),  64'(s_adr_o), 64'(vecs[r].exp_sadr));
            chk($sformatf("vec%0d_ack", r),   64'(m_ack_o), 64'(vecs[r].exp_ack));
            finish_cycle();
        end
        rst = 1'b0;
        clear_inputs();

        // ---------------- burst from slot 2 while slot 1 waits ----------------
        cyc = b2; stb = b2; cti[2] = 3'b010; adr[2] = 32'h0000_2000;
        @(negedge clk);
        chk("burst_idle_grant", 64'(grant_o), 64'h0);
        finish_cycle();
        for (int beat = 0; beat < 4; beat++) begin
            exp_cti = (beat == 3) ? 3'b111 : 3'b010;
            cyc = b1 | b2; stb = b1 | b2;
            cti[2] = exp_cti;
            adr[2] = 32'h0000_2000 + 32'(4 * beat);
            s_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("burst%0d_grant", beat), 64'(grant_o), 64'(b2));
            chk($sformatf("burst%0d_cti", beat),   64'(s_cti_o), 64'(exp_cti));
            chk($sformatf("burst%0d_adr", beat),   64'(s_adr_o), 64'(32'h0000_2000 + 32'(4 * beat)));
            chk($sformatf("burst%0d_ack", beat),   64'(m_ack_o), 64'(b2));
            finish_cycle();
        end
        cyc = b1; stb = b1; s_ack = 1'b0; cti[2] = 3'b000;
        @(negedge clk);
        chk("burst_release_scyc", 64'(s_cyc_o), 64'h0);
        finish_cycle();
        @(negedge clk);
        chk("burst_gap_grant", 64'(grant_o), 64'h0);
        finish_cycle();
        @(negedge clk);
        chk("burst_next_grant", 64'(grant_o), 64'(b1));
        finish_cycle();
        cyc = '0; stb = '0;
        @(negedge clk);
        finish_cycle();
        @(negedge clk);
        finish_cycle();

        // ---------------- reset while slot 7 is mid-transfer ----------------
        cyc = b7; stb = b7;
        @(negedge clk);
        finish_cycle();
        @(negedge clk);
        chk("rst_pre_grant", 64'(grant_o), 64'(b7));
        finish_cycle();
        rst = 1'b1;
        @(negedge clk);
        finish_cycle();
        rst = 1'b0; cyc = b0 | b7; stb = b0 | b7; s_ack = 1'b1;
        @(negedge clk);
        chk("rst_post_grant", 64'(grant_o), 64'h0);
        chk("rst_post_scyc",  64'(s_cyc_o), 64'h0);
        chk("rst_post_ack",   64'(m_ack_o), 64'h0);
        finish_cycle();
        s_ack = 1'b0;
        @(negedge clk);
        chk("rst_ptr_restart", 64'(grant_o), 64'(b0));
        finish_cycle();
        cyc = '0; stb = '0;
        @(negedge clk);
        finish_cycle();
        @(negedge clk);
        finish_cycle();

        // ---------------- slave never answers slot 9 ----------------
        cyc = b9; stb = b9;
        @(negedge clk);
        chk("stall_idle_grant", 64'(grant_o), 64'h0);
        finish_cycle();
`ifdef WB_EXT_ARB_TIMEOUT_EN
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_err", s),  64'(m_err_o),   (s == 4) ? 64'(b9) : 64'h0);
            chk($sformatf("stall%0d_tmo", s),  64'(timeout_o), (s == 4) ? 64'h1 : 64'h0);
            chk($sformatf("stall%0d_scyc", s), 64'(s_cyc_o),   (s == 4) ? 64'h0 : 64'h1);
            finish_cycle();
        end
        cyc = '0; stb = '0;
        @(negedge clk);
        chk("stall_after_grant", 64'(grant_o), 64'h0);
        finish_cycle();
`else
        for (int s = 0; s < 100; s++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_grant", s), 64'(grant_o), 64'(b9));
            finish_cycle();
        end
        cyc = '0; stb = '0;
        @(negedge clk);
        finish_cycle();
`endif
        @(negedge clk);
        finish_cycle();

        // ---------------- random traffic against the model ----------------
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < c_n; i++) begin
                if (cyc[i]) begin
                    if ($urandom_range(0, 5) == 0) cyc[i] = 1'b0;
                end else if ($urandom_range(0, 39) == 0) begin
                    cyc[i] = 1'b1;
                end
                stb[i] = cyc[i] & ($urandom_range(0, 3) != 0);
                we[i]  = 1'($urandom);
                cab[i] = 1'($urandom);
                adr[i] = $urandom;
                dat[i] = $urandom;
                sel[i] = 4'($urandom);
                cti[i] = 3'($urandom);
                bte[i] = 2'($urandom);
            end
            s_ack = ($urandom_range(0, 2) == 0);
            s_err = ($urandom_range(0, 19) == 0);
            s_rty = ($urandom_range(0, 19) == 0);
            s_dat = $urandom;
            rst   = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            finish_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
